// File: rtl/dma_arb.sv
// ============================================================================
// Module  : dma_arb
// Brief   : Round-robin DMA requester arbiter with in-order completion tags.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dma_arb #(
    parameter int NREQ   = 4,
    parameter int TDEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*22-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rnw,
    input  logic [NREQ*8-1:0] req_wd,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rd,
    output logic              dma_req,
    output logic [21:0]       dma_addr,
    output logic              dma_rnw,
    output logic [7:0]        dma_wd,
    input  logic              dma_ack,
    input  logic              dma_end,
    input  logic [7:0]        dma_rd,
    output logic              err
);

    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TDEPTH > 1) ? $clog2(TDEPTH) : 1;

    logic [LW-1:0] last;
    logic [LW-1:0] sel;
    logic          any_req;
    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW:0]   count;
    logic [LW-1:0] tags [TDEPTH];
    logic          tag_full;
    logic          empty;
    logic          push;
    logic          pop;

    // First requesting slot searching upward from last+1, wrapping.
    always_comb begin
        int            pos;
        logic [LW-1:0] idx;
        logic          found;
        sel   = '0;
        found = 1'b0;
        pos   = 0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = (int'(last) + k) % NREQ;
            idx = LW'(pos);
            if (!found && req[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        dma_addr = '0;
        dma_rnw  = 1'b0;
        dma_wd   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (any_req && sel == LW'(i)) begin
                dma_addr = req_addr[22*i +: 22];
                dma_rnw  = req_rnw[i];
                dma_wd   = req_wd[8*i +: 8];
            end
        end
    end

    assign any_req  = |req;
    assign tag_full = (count == (PW+1)'(TDEPTH));
    assign empty    = (count == '0);
    assign dma_req  = any_req & ~tag_full & ~rst;
    assign push     = dma_req & dma_ack;
    assign pop      = dma_end & ~empty & ~rst;

    assign ack  = push ? (NREQ'(1) << sel) : '0;
    assign done = pop ? (NREQ'(1) << tags[rp]) : '0;
    assign rd   = pop ? dma_rd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last  <= LW'(NREQ-1);
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            err   <= 1'b0;
        end else begin
            if (push) begin
                last <= sel;
                wp   <= wp + 1'b1;
            end
            if (pop) begin
                rp <= rp + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            // A completion with nothing outstanding is a sequencer protocol error.
            if (dma_end && empty) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tags[wp] <= sel;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dma_arb.sv
// ============================================================================
// Module  : tb_dma_arb
// Brief   : Directed and random self-checking bench for dma_arb.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dma_arb;

    localparam int NREQ   = 4;
    localparam int TDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [87:0] req_addr;
    logic [3:0]  req_rnw;
    logic [31:0] req_wd;
    logic [3:0]  ack;
    logic [3:0]  done;
    logic [7:0]  rd;
    logic        dma_req;
    logic [21:0] dma_addr;
    logic        dma_rnw;
    logic [7:0]  dma_wd;
    logic        dma_ack;
    logic        dma_end;
    logic [7:0]  dma_rd;
    logic        err;

    dma_arb #(.NREQ(NREQ), .TDEPTH(TDEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .req_rnw  (req_rnw),
        .req_wd   (req_wd),
        .ack      (ack),
        .done     (done),
        .rd       (rd),
        .dma_req  (dma_req),
        .dma_addr (dma_addr),
        .dma_rnw  (dma_rnw),
        .dma_wd   (dma_wd),
        .dma_ack  (dma_ack),
        .dma_end  (dma_end),
        .dma_rd   (dma_rd),
        .err      (err)
    );

    always #5 clk = ~clk;

    int   ncmp = 0;
    int   nfail = 0;
    int   m_last;
    int   m_q[$];
    bit   m_err;
    logic [3:0]  o_ack, o_done;
    logic [7:0]  o_rd;
    logic        o_dreq, o_err;
    logic [21:0] o_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus; the model predicts outputs, m_q is the tag scoreboard.
    task automatic step(input logic r, input logic [3:0] rq, input logic dack,
                        input logic dend, input logic [7:0] drd);
        int   sel;
        bit   found, dreq, pop, bad_end;
        logic [3:0]  eack, edone;
        logic [7:0]  erd;
        @(negedge clk);
        rst = r; req = rq; dma_ack = dack; dma_end = dend; dma_rd = drd;
        #1;
        if (r) begin
            m_q.delete();
            m_last = NREQ - 1;
            m_err  = 1'b0;
        end
        sel = 0; found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (!found && rq[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        dreq    = found && (m_q.size() < TDEPTH) && !r;
        pop     = dend && (m_q.size() > 0) && !r;
        bad_end = dend && (m_q.size() == 0) && !r;
        eack    = (dreq && dack) ? 4'(1 << sel) : 4'h0;
        edone   = pop ? 4'(1 << m_q[0]) : 4'h0;
        erd     = pop ? drd : 8'h00;
        o_ack = ack; o_done = done; o_rd = rd; o_dreq = dma_req; o_err = err; o_addr = dma_addr;
        chk("dma_req", {31'd0, dma_req}, {31'd0, dreq});
        chk("ack", {28'd0, ack}, {28'd0, eack});
        chk("done", {28'd0, done}, {28'd0, edone});
        chk("rd", {24'd0, rd}, {24'd0, erd});
        chk("err", {31'd0, err}, {31'd0, m_err});
        if (found) begin
            chk("dma_addr", {10'd0, dma_addr}, {10'd0, req_addr[22*sel +: 22]});
            chk("dma_rnw", {31'd0, dma_rnw}, {31'd0, req_rnw[sel]});
            chk("dma_wd", {24'd0, dma_wd}, {24'd0, req_wd[8*sel +: 8]});
        end else begin
            chk("dma_addr_idle", {10'd0, dma_addr}, 32'd0);
        end
        if (pop) void'(m_q.pop_front());
        if (dreq && dack) begin
            m_q.push_back(sel);
            m_last = sel;
        end
        if (bad_end) m_err = 1'b1;
    endtask

    initial begin
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1; req = '0; dma_ack = 1'b0; dma_end = 1'b0; dma_rd = '0;
        req_addr = {22'h3ABCDE, 22'h012345, 22'h155555, 22'h00F00F};
        req_rnw  = 4'b0101;
        req_wd   = 32'hC3B2A190;

        // Reset holds everything quiet even with requests and an end pending.
        step(1, 4'hF, 1, 1, 8'hEE);
        chk("rst_dreq", {31'd0, o_dreq}, 32'd0);
        chk("rst_ack", {28'd0, o_ack}, 32'd0);
        step(0, 4'h0, 0, 0, 8'h00);

        // Round robin with all requesters active.
        for (int i = 0; i < 5; i++) begin
            step(0, 4'hF, 1, (i > 0), 8'(8'h40 + i));
            chk("rr_seq", {28'd0, o_ack}, {28'd0, rr_exp[i]});
        end
        step(0, 4'h0, 0, 1, 8'h33);
        chk("rr_drain", {28'd0, o_done}, 32'h1);

        // Slot 2 read with completion three cycles later.
        req_addr[44 +: 22] = 22'h012345;
        req_rnw[2] = 1'b1;
        step(0, 4'b0100, 1, 0, 8'h00);
        chk("s2_ack", {28'd0, o_ack}, 32'h4);
        chk("s2_addr", {10'd0, o_addr}, 32'h012345);
        step(0, 4'h0, 0, 0, 8'h00);
        step(0, 4'h0, 0, 0, 8'h00);
        step(0, 4'h0, 0, 1, 8'hA5);
        chk("s2_done", {28'd0, o_done}, 32'h4);
        chk("s2_rd", {24'd0, o_rd}, 32'hA5);

        // Fill the tag FIFO; full blocks even in the cycle of a completion.
        for (int i = 0; i < 4; i++) step(0, 4'hF, 1, 0, 8'h00);
        step(0, 4'hF, 1, 0, 8'h00);
        chk("full_block", {31'd0, o_dreq}, 32'd0);
        step(0, 4'hF, 1, 1, 8'h11);
        chk("full_end_done", {28'd0, o_done}, 32'h8);
        chk("full_end_block", {31'd0, o_dreq}, 32'd0);
        step(0, 4'hF, 1, 0, 8'h00);
        chk("full_resume", {31'd0, o_dreq}, 32'd1);
        for (int i = 0; i < 4; i++) step(0, 4'h0, 0, 1, 8'(8'h20 + i));

        // Push and pop together with two entries held.
        step(0, 4'hF, 1, 0, 8'h00);
        step(0, 4'hF, 1, 0, 8'h00);
        step(0, 4'hF, 1, 1, 8'h51);
        chk("pp_done", {28'd0, o_done}, 32'h1);
        step(0, 4'h0, 0, 1, 8'h52);
        chk("pp_order1", {28'd0, o_done}, 32'h2);
        step(0, 4'h0, 0, 1, 8'h53);
        chk("pp_order2", {28'd0, o_done}, 32'h4);

        // Completion with nothing outstanding is sticky.
        step(0, 4'h0, 0, 1, 8'h77);
        chk("empty_end_done", {28'd0, o_done}, 32'h0);
        step(0, 4'h0, 0, 0, 8'h00);
        chk("err_set", {31'd0, o_err}, 32'd1);

        for (int i = 0; i < 40; i++) begin
            if (i % 8 == 0) begin
                req_addr = {$urandom, $urandom, $urandom};
                req_wd   = $urandom;
                req_rnw  = 4'($urandom);
            end
            step(0, 4'($urandom), 1'($urandom), ($urandom_range(0, 2) == 0), 8'($urandom));
        end
        chk("err_sticky", {31'd0, o_err}, 32'd1);

        // Reset with three transfers outstanding discards them.
        step(1, 4'h0, 0, 0, 8'h00);
        step(0, 4'h0, 0, 0, 8'h00);
        for (int i = 0; i < 3; i++) step(0, 4'hF, 1, 0, 8'h00);
        step(1, 4'hF, 1, 1, 8'h99);
        chk("mid_rst_done", {28'd0, o_done}, 32'h0);
        step(0, 4'h0, 0, 1, 8'h9A);
        chk("late_end_done", {28'd0, o_done}, 32'h0);
        step(0, 4'hF, 1, 0, 8'h00);
        chk("late_end_err", {31'd0, o_err}, 32'd1);
        chk("post_rst_grant", {28'd0, o_ack}, 32'h1);
        step(0, 4'h0, 0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dma_arb.md
DMA_ARB -- requirements
Module: dma_arb

Interface
REQ-001 Parameters SHALL be: NREQ, default 4, number of DMA requesters (2..8); TDEPTH, default 4, outstanding-transfer tag FIFO depth (power of 2).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high; one clock, reset is asynchronous and active-high.
REQ-004 req  input  NREQ  per-requester DMA request; held high until the matching ack.
REQ-005 req_addr  input  NREQ*22  packed per-requester byte addresses; slot i occupies bits [22*i+21:22*i].
REQ-006 req_rnw  input  NREQ  per-requester direction: 1 = read, 0 = write.
REQ-007 req_wd  input  NREQ*8  packed per-requester write data; slot i occupies bits [8*i+7:8*i].
REQ-008 ack  output  NREQ  one-cycle pulse: the request of slot i was accepted downstream.
REQ-009 done  output  NREQ  one-cycle pulse: the transfer of slot i has completed.
REQ-010 rd  output  8  read data, valid in the cycle any done bit is high.
REQ-011 dma_req  output  1  request to the shared DMA sequencer.
REQ-012 dma_addr, dma_rnw, dma_wd  output  22/1/8  muxed address, direction and write data of the selected slot.
REQ-013 dma_ack  input  1  sequencer accepted the current request; the transfer counts only when dma_req=1.
REQ-014 dma_end  input  1  one-cycle pulse: the oldest outstanding transfer has completed.
REQ-015 dma_rd  input  8  sequencer read data, valid with dma_end.
REQ-016 err  output  1  sticky protocol-error flag.

Function
REQ-017 Selection SHALL be combinational round-robin: the first slot with req=1, searching upward from (last+1) mod NREQ and wrapping.
REQ-018 last SHALL be a log2(NREQ)-bit register that is loaded with the selected index only on an accepted transfer (dma_req & dma_ack).
REQ-019 dma_req SHALL equal (|req) & !tag_full.
REQ-020 dma_addr, dma_rnw and dma_wd SHALL be the fields of the selected slot, and SHALL be 0 when no req is high.
REQ-021 ack[i] SHALL equal dma_req & dma_ack & (sel==i), with zero added latency; at most one ack bit is high per cycle.
REQ-022 On each accepted transfer the selected index SHALL be pushed into a TDEPTH-entry in-order tag FIFO.
REQ-023 On dma_end with the FIFO non-empty, the head tag SHALL be popped and done[head] asserted in the same cycle; rd SHALL equal dma_rd in that cycle.
REQ-024 A push and a pop in the same cycle SHALL both take effect, and the occupancy SHALL be unchanged.
REQ-025 tag_full (occupancy==TDEPTH) SHALL force dma_req=0; requests stay pending with no ack.
REQ-026 A full FIFO with a simultaneous dma_end SHALL still block new requests in that cycle; the freed slot becomes usable the next cycle.
REQ-027 dma_end while the FIFO is empty SHALL set err, assert no done bit, and leave occupancy unchanged.
REQ-028 err SHALL clear only on rst.
REQ-029 A requester dropping req without an ack SHALL lose its turn silently, with no error.
REQ-030 The FIFO read/write pointers SHALL wrap modulo TDEPTH; occupancy SHALL be a log2(TDEPTH)+1-bit counter.
REQ-031 Write transfers SHALL also produce done, so every ack has exactly one later done.

Reset
REQ-032 rst high SHALL immediately force: last=NREQ-1 (slot 0 wins first), FIFO empty, err=0, ack=0, done=0, rd=0.
REQ-033 dma_req SHALL be low during reset regardless of req.
REQ-034 Reset mid-operation SHALL discard all outstanding tags; any dma_end arriving after reset is released SHALL set err.

Verification
REQ-035 Scenario: req=4'b1111 held, dma_ack=1 each cycle -> ack sequence 0001,0010,0100,1000,0001.
REQ-036 Scenario: slot 2 reads addr 22'h012345 and dma_end arrives 3 cycles after ack with dma_rd=8'hA5 -> done=4'b0100 and rd=8'hA5 on that cycle; dma_addr=22'h012345 during the request.
REQ-037 Scenario: 4 acks with no dma_end -> dma_req=0 while req is held; one dma_end -> done to the first-acked slot, and dma_req returns the next cycle.
REQ-038 Scenario: FIFO holds 2 entries, ack and end in the same cycle -> occupancy stays 2; the tag order is preserved.
REQ-039 Scenario: dma_end with the FIFO empty -> err=1, done=0; err stays 1 until rst.
REQ-040 Scenario: rst asserted with 3 transfers outstanding -> the FIFO is empty; the next grant goes to slot 0; the late dma_end sets err.
